// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, types and helpers for the regfile_mp register file.
//   - WR_* : write-back load formats (word, lbu, lb, lh)
//   - RD_* : read-port formats (word, byte zero-extend, half zero-extend)
//   - state_e : clear sequencer states
//   - fmt_write() : applies a write-back load format to raw data
package regfile_pkg;

  // Widest register the helper functions support; modules cast down to DATA_W.
  localparam int REG_MAX_W = 64;

  localparam logic [1:0] WR_WORD = 2'b00;
  localparam logic [1:0] WR_LBU  = 2'b01;
  localparam logic [1:0] WR_LB   = 2'b10;
  localparam logic [1:0] WR_LH   = 2'b11;

  localparam logic [1:0] RD_WORD = 2'b00;
  localparam logic [1:0] RD_BYTE = 2'b01;
  localparam logic [1:0] RD_HALF = 2'b10;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Data is zero-extended to REG_MAX_W by the caller. Sign extension is done
  // to the full REG_MAX_W, so truncating the result to any DATA_W >= 16 keeps
  // the correct sign bits in the upper part.
  function automatic logic [REG_MAX_W-1:0] fmt_write(input logic [REG_MAX_W-1:0] data,
                                                     input logic [1:0]           mode);
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic [REG_MAX_W-1:0] res;
    byte_s = $signed(data[7:0]);
    half_s = $signed(data[15:0]);
    case (mode)
      WR_LBU:  res = REG_MAX_W'(data[7:0]);
      WR_LB:   res = REG_MAX_W'(byte_s);
      WR_LH:   res = REG_MAX_W'(half_s);
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/regfile_rd_fmt.sv
// regfile_rd_fmt: combinational read-port formatter.
//   base_i : register value selected for this port (after bypass / zero handling)
//   mode_i : RD_WORD, RD_BYTE (zero-extend [7:0]), RD_HALF (zero-extend [15:0]);
//            the reserved code 2'b11 behaves as RD_WORD
//   data_o : formatted value, registered by the parent
module regfile_rd_fmt
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] base_i,
  input  logic [1:0]        mode_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = base_i;
    case (mode_i)
      RD_BYTE: data_o = DATA_W'(base_i[7:0]);
      RD_HALF: data_o = DATA_W'(base_i[15:0]);
      default: data_o = base_i;
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with load-format write-back.
//   Clk, Rst : clock, synchronous active-high reset
//   Rd_addr  : NUM_RD packed read indices, port k at [k*ADDR_W +: ADDR_W]
//   Rd_mode  : NUM_RD packed 2-bit read formats
//   Rd_data  : NUM_RD packed registered read results (latency 1)
//   Wr_en, Wr_addr, Wr_data, Wr_mode : single write port with load formatting
//   Busy     : high while the post-reset clear sequencer runs
// Entry 0 always reads as zero. After reset every other entry is cleared one
// per cycle; reads return zero and writes are dropped during that time.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [NUM_RD*ADDR_W-1:0] Rd_addr,
  input  logic [NUM_RD*2-1:0]      Rd_mode,
  output logic [NUM_RD*DATA_W-1:0] Rd_data,
  input  logic                     Wr_en,
  input  logic [ADDR_W-1:0]        Wr_addr,
  input  logic [DATA_W-1:0]        Wr_data,
  input  logic [1:0]               Wr_mode,
  output logic                     Busy
);

  localparam int               DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          idx_q, idx_d;
  logic                       busy_q, busy_d;
  logic [NUM_RD*DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [DATA_W-1:0]          mem_q [DEPTH];

  logic [DATA_W-1:0]          wr_fmt;
  logic                       wr_fire;
  logic                       mem_we;
  logic [ADDR_W-1:0]          mem_waddr;
  logic [DATA_W-1:0]          mem_wdata;

  // Write port: formatting, acceptance and sharing of the array port with the
  // clear sequencer (which owns it for the whole CLEAR state).
  always_comb begin
    wr_fmt    = DATA_W'(fmt_write(REG_MAX_W'(Wr_data), Wr_mode));
    wr_fire   = Wr_en && (state_q == RUN) && (Wr_addr != '0);
    mem_we    = 1'b0;
    mem_waddr = Wr_addr;
    mem_wdata = wr_fmt;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = idx_q;
      mem_wdata = '0;
    end else if (wr_fire) begin
      mem_we = 1'b1;
    end
  end

  // Clear sequencer next state: index 0 is never stored, so the walk starts
  // at 1 and hands over to RUN once the last index has been written.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    if (state_q == CLEAR) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == LAST_IDX) begin
        state_d = RUN;
        busy_d  = 1'b0;
      end
    end
  end

  // Read ports: zero / bypass / array select, then per-port formatting.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] base;

    assign raddr = Rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      if ((raddr == '0) || busy_q) begin
        base = '0;
      end else if (wr_fire && (Wr_addr == raddr)) begin
        base = wr_fmt;
      end else begin
        base = mem_q[raddr];
      end
    end

    regfile_rd_fmt #(
      .DATA_W (DATA_W)
    ) u_rd_fmt (
      .base_i (base),
      .mode_i (Rd_mode[k*2 +: 2]),
      .data_o (rd_data_d[k*DATA_W +: DATA_W])
    );
  end

  // Registered stage: sequencer state and read results.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= CLEAR;
      idx_q     <= ADDR_W'(1);
      busy_q    <= 1'b1;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
    end
  end

  // The array is left untouched on a reset edge; clearing happens afterwards.
  always_ff @(posedge Clk) begin
    if (!Rst && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign Rd_data = rd_data_q;
  assign Busy    = busy_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp. Instance A uses the default
// parameters, instance B uses DATA_W=16 / NUM_RD=4. Read expectations are
// queued when a read is driven and compared when the registered result appears.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic        a_rst, a_wr_en, a_busy;
  logic [9:0]  a_raddr;
  logic [3:0]  a_rmode;
  logic [63:0] a_rdata;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic [1:0]  a_wmode;

  // Instance B: 16-bit data, four read ports
  logic        b_rst, b_wr_en, b_busy;
  logic [19:0] b_raddr;
  logic [7:0]  b_rmode;
  logic [63:0] b_rdata;
  logic [4:0]  b_waddr;
  logic [15:0] b_wdata;
  logic [1:0]  b_wmode;

  regfile_mp u_dut_a (
    .Clk     (clk),
    .Rst     (a_rst),
    .Rd_addr (a_raddr),
    .Rd_mode (a_rmode),
    .Rd_data (a_rdata),
    .Wr_en   (a_wr_en),
    .Wr_addr (a_waddr),
    .Wr_data (a_wdata),
    .Wr_mode (a_wmode),
    .Busy    (a_busy)
  );

  regfile_mp #(
    .DATA_W (16),
    .ADDR_W (5),
    .NUM_RD (4)
  ) u_dut_b (
    .Clk     (clk),
    .Rst     (b_rst),
    .Rd_addr (b_raddr),
    .Rd_mode (b_rmode),
    .Rd_data (b_rdata),
    .Wr_en   (b_wr_en),
    .Wr_addr (b_waddr),
    .Wr_data (b_wdata),
    .Wr_mode (b_wmode),
    .Busy    (b_busy)
  );

  typedef struct {
    string       tag;
    int          dut;
    int          port;
    logic [31:0] exp;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] obs(input int dut, input int port);
    if (dut == 0) return a_rdata[port*32 +: 32];
    return {16'h0000, b_rdata[port*16 +: 16]};
  endfunction

  // One clock: sample 1 time unit after the edge, retire due expectations,
  // then drop any single-cycle write request.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk(e.tag, obs(e.dut, e.port), e.exp);
    end
    a_wr_en = 1'b0;
    b_wr_en = 1'b0;
  endtask

  task automatic push(input string tag, input int dut, input int port, input logic [31:0] exp);
    exp_t e;
    e.tag  = tag;
    e.dut  = dut;
    e.port = port;
    e.exp  = exp;
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  task automatic a_rd(input int port, input logic [4:0] addr, input logic [1:0] mode,
                      input string tag, input logic [31:0] exp);
    a_raddr[port*5 +: 5] = addr;
    a_rmode[port*2 +: 2] = mode;
    push(tag, 0, port, exp);
  endtask

  task automatic b_rd(input int port, input logic [4:0] addr, input logic [1:0] mode,
                      input string tag, input logic [15:0] exp);
    b_raddr[port*5 +: 5] = addr;
    b_rmode[port*2 +: 2] = mode;
    push(tag, 1, port, {16'h0000, exp});
  endtask

  task automatic a_wr(input logic [4:0] addr, input logic [31:0] data, input logic [1:0] mode);
    a_wr_en = 1'b1;
    a_waddr = addr;
    a_wdata = data;
    a_wmode = mode;
  endtask

  task automatic b_wr(input logic [4:0] addr, input logic [15:0] data, input logic [1:0] mode);
    b_wr_en = 1'b1;
    b_waddr = addr;
    b_wdata = data;
    b_wmode = mode;
  endtask

  task automatic pulse_reset();
    a_rst = 1'b1;
    b_rst = 1'b1;
    step();
    a_rst = 1'b0;
    b_rst = 1'b0;
  endtask

  // Counts cycles with Busy high on each instance (bounded). While busy,
  // port 0 of A reads a non-zero index and must see zero; with poke set,
  // writes to index 3 are issued and must be dropped.
  task automatic busy_run(input bit poke, output int na, output int nb);
    int it;
    it = 0;
    na = 0;
    nb = 0;
    while ((a_busy === 1'b1 || b_busy === 1'b1) && it < 100) begin
      if (a_busy === 1'b1) na++;
      if (b_busy === 1'b1) nb++;
      if (poke && (it == 2 || it == 20)) begin
        a_wr(5'd3, 32'h0000_0055, WR_WORD);
        b_wr(5'd3, 16'h0055, WR_WORD);
      end
      a_rd(0, 5'd8, RD_WORD, "busy_rd_zero", 32'h0);
      step();
      it++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] exp;
  } ld_t;

  initial begin
    int   na, nb;
    ld_t  ld_tab[4];

    a_rst = 1'b1; b_rst = 1'b1;
    a_raddr = '0; a_rmode = '0; a_wr_en = 1'b0; a_waddr = '0; a_wdata = '0; a_wmode = '0;
    b_raddr = '0; b_rmode = '0; b_wr_en = 1'b0; b_waddr = '0; b_wdata = '0; b_wmode = '0;
    step();
    pulse_reset();

    // Reset state
    chk("rst_busy_a", {31'b0, a_busy}, 32'h1);
    chk("rst_busy_b", {31'b0, b_busy}, 32'h1);
    chk("rst_rdata_a0", a_rdata[31:0], 32'h0);
    chk("rst_rdata_a1", a_rdata[63:32], 32'h0);
    chk("rst_rdata_b01", b_rdata[31:0], 32'h0);
    chk("rst_rdata_b23", b_rdata[63:32], 32'h0);

    busy_run(1'b0, na, nb);
    chk("busy_len_a", na, 32'd31);
    chk("busy_len_b", nb, 32'd31);

    // Whole array reads zero after the clear
    for (int i = 0; i < 32; i++) begin
      a_rd(0, 5'(i), RD_WORD, "clr_a_p0", 32'h0);
      a_rd(1, 5'(31 - i), RD_HALF, "clr_a_p1", 32'h0);
      for (int p = 0; p < 4; p++) b_rd(p, 5'(i), RD_WORD, "clr_b", 16'h0);
      step();
    end

    // Dirty two entries, then reset again mid-clear
    a_wr(5'd8, 32'h0000_1234, WR_WORD);
    b_wr(5'd8, 16'h1234, WR_WORD);
    step();
    a_wr(5'd3, 32'h0000_AAAA, WR_WORD);
    b_wr(5'd3, 16'hAAAA, WR_WORD);
    step();
    a_rd(0, 5'd3, RD_WORD, "pre_rst_3", 32'h0000_AAAA);
    step();
    pulse_reset();
    for (int i = 0; i < 9; i++) step();
    chk("midclr_busy", {31'b0, a_busy}, 32'h1);
    pulse_reset();
    busy_run(1'b1, na, nb);
    chk("rebusy_len_a", na, 32'd31);
    chk("rebusy_len_b", nb, 32'd31);

    // Dropped writes during Busy, and previously written entries cleared
    a_rd(0, 5'd3, RD_WORD, "drop3_a", 32'h0);
    a_rd(1, 5'd8, RD_WORD, "clr8_a", 32'h0);
    for (int p = 0; p < 4; p++) b_rd(p, 5'd3, RD_WORD, "drop3_b", 16'h0);
    step();

    // Word writes and reads
    a_wr(5'd8, 32'h0000_0A12, WR_WORD);
    step();
    a_rd(0, 5'd8, RD_WORD, "word8_p0", 32'h0000_0A12);
    a_wr(5'd19, 32'h0000_00FF, WR_WORD);
    step();
    a_rd(1, 5'd19, RD_WORD, "word19_p1", 32'h0000_00FF);
    step();

    // Load formats
    ld_tab[0] = '{WR_LBU,  32'h0000_0080};
    ld_tab[1] = '{WR_LB,   32'hFFFF_FF80};
    ld_tab[2] = '{WR_LH,   32'hFFFF_8F80};
    ld_tab[3] = '{WR_WORD, 32'hFFFF_8F80};
    for (int i = 0; i < 4; i++) begin
      a_wr(5'd8, 32'hFFFF_8F80, ld_tab[i].mode);
      step();
      a_rd(0, 5'd8, RD_WORD, $sformatf("load_mode%0d", ld_tab[i].mode), ld_tab[i].exp);
      step();
    end

    // Read formats on one entry, two ports same cycle
    a_wr(5'd19, 32'h1234_5678, WR_WORD);
    step();
    a_rd(1, 5'd19, RD_BYTE, "rd_byte19_p1", 32'h0000_0078);
    a_rd(0, 5'd19, RD_WORD, "rd_word19_p0", 32'h1234_5678);
    step();
    a_rd(1, 5'd19, RD_HALF, "rd_half19_p1", 32'h0000_5678);
    a_rd(0, 5'd19, 2'b11, "rd_rsv19_p0", 32'h1234_5678);
    step();

    // Bypass, plain and through a load format
    a_wr(5'd5, 32'hDEAD_BEEF, WR_WORD);
    a_rd(0, 5'd5, RD_WORD, "byp5_p0", 32'hDEAD_BEEF);
    a_rd(1, 5'd5, RD_BYTE, "byp5_p1_byte", 32'h0000_00EF);
    step();
    a_wr(5'd6, 32'h0000_0080, WR_LB);
    a_rd(0, 5'd6, RD_WORD, "byp6_lb", 32'hFFFF_FF80);
    a_rd(1, 5'd5, RD_WORD, "keep5", 32'hDEAD_BEEF);
    step();

    // Register zero
    a_wr(5'd0, 32'hFFFF_FFFF, WR_WORD);
    a_rd(0, 5'd0, RD_WORD, "zero_byp", 32'h0);
    step();
    a_rd(1, 5'd0, RD_WORD, "zero_rd", 32'h0);
    a_rd(0, 5'd6, RD_HALF, "rd_half6", 32'h0000_FF80);
    step();

    // Narrow, four-port instance
    b_wr(5'd7, 16'h0080, WR_LB);
    step();
    b_rd(0, 5'd7, RD_WORD, "b_lb7_word", 16'hFF80);
    b_rd(1, 5'd7, RD_BYTE, "b_lb7_byte", 16'h0080);
    b_rd(2, 5'd7, RD_HALF, "b_lb7_half", 16'hFF80);
    b_rd(3, 5'd7, 2'b11,   "b_lb7_rsv", 16'hFF80);
    step();
    b_wr(5'd9, 16'h8001, WR_LH);
    b_rd(0, 5'd9, RD_WORD, "b_byp9_word", 16'h8001);
    b_rd(3, 5'd9, RD_BYTE, "b_byp9_byte", 16'h0001);
    step();
    b_wr(5'd10, 16'hABCD, WR_LBU);
    b_rd(2, 5'd10, RD_WORD, "b_byp10_lbu", 16'h00CD);
    b_rd(1, 5'd9, RD_WORD, "b_keep9", 16'h8001);
    b_rd(0, 5'd0, RD_WORD, "b_zero", 16'h0);
    step();

    step();
    chk("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
